// File: rtl/cdb_sched_pkg.sv
// Shared types for the common data bus scheduler and its consumers.
package cdb_sched_pkg;

    localparam int unsigned ROB_W  = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned MASK_W = 4;

    // One result broadcast on the CDB.
    typedef struct packed {
        logic [ROB_W-1:0]  rob_entry;
        logic [REG_W-1:0]  rd_addr;
        logic [XLEN-1:0]   rd_data;
        logic [XLEN-1:0]   mem_addr;
        logic [MASK_W-1:0] mem_rmask;
        logic [MASK_W-1:0] mem_wmask;
    } cdb_t;

endpackage

// File: rtl/cdb_sched_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found_c,
    output logic [IW-1:0] idx_c
);

    logic [IW-1:0] cand;

    // Walk ptr, ptr+1, ... and keep the first requester seen.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!found_c && req[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/cdb_sched.sv
// CDB arbiter: starvation override, then strict priority source, then round-robin.
// Grant is combinational; the broadcast is registered one cycle later.
module cdb_sched
    import cdb_sched_pkg::*;
#(
    parameter int unsigned N_SRC        = 5,
    parameter int unsigned PRIO_SRC     = 3,
    parameter int unsigned LS_IDX       = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [N_SRC-1:0]         src_valid,
    input  cdb_t                     src_data [N_SRC],
    output logic [N_SRC-1:0]         src_ack,
    output logic                     cdb_en,
    output cdb_t                     cdb_out,
    output logic [$clog2(N_SRC)-1:0] cdb_src
);

    localparam int unsigned IW = $clog2(N_SRC);
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

    logic [IW-1:0]    rr_ptr;
    logic [WW-1:0]    wait_cnt [N_SRC];
    logic [N_SRC-1:0] starved;
    logic             starve_found, rr_found, grant_vld;
    logic [IW-1:0]    starve_idx, rr_idx, grant_idx;
    cdb_t             bcast;

    // Sources that have waited long enough to override priority.
    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            starved[i] = src_valid[i] && (wait_cnt[i] == WW'(STARVE_LIMIT));
        end
    end

    rr_pick #(.N(N_SRC), .IW(IW)) u_starve_pick (
        .req     (starved),
        .ptr     ('0),
        .found_c (starve_found),
        .idx_c   (starve_idx)
    );

    rr_pick #(.N(N_SRC), .IW(IW)) u_rr_pick (
        .req     (src_valid),
        .ptr     (rr_ptr),
        .found_c (rr_found),
        .idx_c   (rr_idx)
    );

    // Grant selection; nothing is granted during reset or flush.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (rst && !flush) begin
            if (starve_found) begin
                grant_vld = 1'b1;
                grant_idx = starve_idx;
            end else if (src_valid[PRIO_SRC]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(PRIO_SRC);
            end else if (rr_found) begin
                grant_vld = 1'b1;
                grant_idx = rr_idx;
            end
        end
        src_ack = '0;
        if (grant_vld) begin
            src_ack[grant_idx] = 1'b1;
        end
    end

    // Winning payload; only the load/store unit may carry memory masks.
    always_comb begin
        bcast = src_data[grant_idx];
        if (grant_idx != IW'(LS_IDX)) begin
            bcast.mem_rmask = '0;
            bcast.mem_wmask = '0;
        end
    end

    // Round-robin pointer moves past any non-priority winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant_vld && grant_idx != IW'(PRIO_SRC)) begin
            rr_ptr <= IW'((32'(grant_idx) + 1) % N_SRC);
        end
    end

    // Per-source age counters, saturating at the starvation limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (flush || !src_valid[i] || src_ack[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WW'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + WW'(1);
                end
            end
        end
    end

    // Broadcast register; payload and source hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_en  <= 1'b0;
            cdb_out <= '0;
            cdb_src <= '0;
        end else begin
            cdb_en <= grant_vld;
            if (grant_vld) begin
                cdb_out <= bcast;
                cdb_src <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_cdb_sched.sv
// Bench for cdb_sched: constant vector tables, directed corner sequences and a
// randomized run, all checked against a rule-level reference model.
module tb_cdb_sched;
    import cdb_sched_pkg::*;

    localparam int N    = 5;
    localparam int PRIO = 3;
    localparam int LS   = 4;
    localparam int LIM  = 4;

    logic         clk, rst, flush;
    logic [N-1:0] src_valid, src_ack;
    cdb_t         src_data [N];
    logic         cdb_en;
    cdb_t         cdb_out;
    logic [2:0]   cdb_src;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int   m_wait [N];
    int   m_rr;
    logic m_en;
    cdb_t m_out;
    int   m_src;

    typedef struct {
        logic         fl;
        logic [N-1:0] v;
        logic [N-1:0] ack;
    } vec_t;

    vec_t starve_v [11];
    vec_t rr_v [6];
    vec_t flush_v [6];

    cdb_sched #(.N_SRC(N), .PRIO_SRC(PRIO), .LS_IDX(LS), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .cdb_en    (cdb_en),
        .cdb_out   (cdb_out),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic fl, logic [N-1:0] v, logic [N-1:0] ack);
        vec_t r;
        r.fl = fl; r.v = v; r.ack = ack;
        return r;
    endfunction

    function automatic cdb_t rand_cdb();
        cdb_t c;
        c.rob_entry = ROB_W'($urandom);
        c.rd_addr   = REG_W'($urandom);
        c.rd_data   = $urandom;
        c.mem_addr  = $urandom;
        c.mem_rmask = MASK_W'($urandom);
        c.mem_wmask = MASK_W'($urandom);
        return c;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rules applied to the model's ages and pointer; -1 means no grant.
    function automatic int pick(logic fl, logic [N-1:0] v);
        if (fl) return -1;
        for (int i = 0; i < N; i++) begin
            if (v[i] && m_wait[i] == LIM) return i;
        end
        if (v[PRIO]) return PRIO;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        m_rr  = 0;
        m_en  = 1'b0;
        m_out = '0;
        m_src = 0;
    endtask

    // One cycle: called at posedge+1 with inputs already driven, returns at next posedge+1.
    task automatic step(input logic [N-1:0] tbl, input bit use_tbl);
        int           g;
        logic [N-1:0] ea;
        cdb_t         e;
        g  = pick(flush, src_valid);
        ea = '0;
        if (g >= 0) ea[g] = 1'b1;
        #1;
        chk("src_ack", 128'(src_ack), 128'(ea));
        if (use_tbl) chk("tbl_ack", 128'(src_ack), 128'(tbl));
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (flush || !src_valid[i] || i == g) m_wait[i] = 0;
            else m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
        end
        if (g >= 0) begin
            if (g != PRIO) m_rr = (g + 1) % N;
            e = src_data[g];
            if (g != LS) begin
                e.mem_rmask = '0;
                e.mem_wmask = '0;
            end
            m_out = e;
            m_src = g;
            m_en  = 1'b1;
        end else begin
            m_en = 1'b0;
        end
        #1;
        chk("cdb_en", 128'(cdb_en), 128'(m_en));
        chk("cdb_out", 128'(cdb_out), 128'(m_out));
        chk("cdb_src", 128'(cdb_src), 128'(m_src));
    endtask

    task automatic drive(input logic fl, input logic [N-1:0] v);
        flush     = fl;
        src_valid = v;
        for (int i = 0; i < N; i++) src_data[i] = rand_cdb();
    endtask

    // Reset for one cycle, checking outputs clear while held.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_en", 128'(cdb_en), 128'(0));
        chk("rst_out", 128'(cdb_out), 128'(0));
        chk("rst_src", 128'(cdb_src), 128'(0));
        chk("rst_ack", 128'(src_ack), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        src_valid = '0;
        for (int i = 0; i < N; i++) src_data[i] = '0;
        model_reset();

        // All five valid: priority source first, then starved sources in index order.
        starve_v[0]  = mk(1'b0, 5'b11111, 5'b01000);
        starve_v[1]  = mk(1'b0, 5'b11111, 5'b01000);
        starve_v[2]  = mk(1'b0, 5'b11111, 5'b01000);
        starve_v[3]  = mk(1'b0, 5'b11111, 5'b01000);
        starve_v[4]  = mk(1'b0, 5'b11111, 5'b00001);
        starve_v[5]  = mk(1'b0, 5'b11111, 5'b00010);
        starve_v[6]  = mk(1'b0, 5'b11111, 5'b00100);
        starve_v[7]  = mk(1'b0, 5'b11111, 5'b10000);
        starve_v[8]  = mk(1'b0, 5'b11111, 5'b01000);
        starve_v[9]  = mk(1'b0, 5'b11111, 5'b00001);
        starve_v[10] = mk(1'b0, 5'b11111, 5'b00010);
        // Three low sources, priority idle: plain rotation.
        for (int i = 0; i < 6; i++) begin
            rr_v[i] = mk(1'b0, 5'b00111, 5'b00001 << (i % 3));
        end
        // Flush clears src 0's age: it must wait a full four cycles again.
        flush_v[0] = mk(1'b1, 5'b00001, 5'b00000);
        flush_v[1] = mk(1'b0, 5'b01001, 5'b01000);
        flush_v[2] = mk(1'b0, 5'b01001, 5'b01000);
        flush_v[3] = mk(1'b0, 5'b01001, 5'b01000);
        flush_v[4] = mk(1'b0, 5'b01001, 5'b01000);
        flush_v[5] = mk(1'b0, 5'b01001, 5'b00001);

        @(posedge clk);
        #1;
        do_reset();

        // Single source, masks stripped for a non-LS source.
        drive(1'b0, 5'b00001);
        src_data[0].rob_entry = 6'd7;
        src_data[0].mem_rmask = 4'hF;
        src_data[0].mem_wmask = 4'hF;
        step(5'b00001, 1'b1);
        chk("single_rob", 128'(cdb_out.rob_entry), 128'(7));
        chk("single_rmask", 128'(cdb_out.mem_rmask), 128'(0));
        chk("single_wmask", 128'(cdb_out.mem_wmask), 128'(0));
        drive(1'b0, 5'b00000);
        step('0, 1'b0);

        do_reset();
        foreach (starve_v[i]) begin
            drive(starve_v[i].fl, starve_v[i].v);
            step(starve_v[i].ack, 1'b1);
        end

        do_reset();
        foreach (rr_v[i]) begin
            drive(rr_v[i].fl, rr_v[i].v);
            step(rr_v[i].ack, 1'b1);
        end

        // LS masks pass through; other sources lose them.
        drive(1'b0, 5'b10000);
        src_data[4].mem_rmask = 4'b0011;
        step(5'b10000, 1'b1);
        chk("ls_rmask", 128'(cdb_out.mem_rmask), 128'(4'b0011));
        drive(1'b0, 5'b00010);
        src_data[1].mem_wmask = 4'hF;
        step(5'b00010, 1'b1);
        chk("nonls_wmask", 128'(cdb_out.mem_wmask), 128'(0));

        // Age src 0 to 3 behind the priority source, then flush.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'b01001);
            step(5'b01000, 1'b1);
        end
        chk("pre_flush_en", 128'(cdb_en), 128'(1));
        foreach (flush_v[i]) begin
            drive(flush_v[i].fl, flush_v[i].v);
            step(flush_v[i].ack, 1'b1);
            if (i == 0) chk("flush_en", 128'(cdb_en), 128'(0));
        end

        // Asynchronous reset between edges while a broadcast is up.
        drive(1'b0, 5'b00010);
        step(5'b00010, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_en", 128'(cdb_en), 128'(0));
        chk("async_ack", 128'(src_ack), 128'(0));
        chk("async_src", 128'(cdb_src), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("post_rst_en", 128'(cdb_en), 128'(0));
        step(5'b00010, 1'b1);
        chk("post_rst_bcast", 128'(cdb_en), 128'(1));

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 15) == 0), N'($urandom | $urandom));
            step('0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
